// File: rtl/hps_pio_bridge.sv
// hps_pio_bridge
// Bridges NUM_CH asynchronous four-phase activate/ack handshakes from the HPS
// onto one internal write bus in the CLOCK_50 domain. Each channel keeps its
// own captured address/data. A channel can optionally generate its own address
// with auto-increment, so the HPS can stream data without rewriting hps_addr.
// Channels contend for the bus by fixed priority, with channel 0 highest.
//
// Ports
//   CLOCK_50      system clock
//   hps_reset     asynchronous, active-high reset
//   hps_activate  per-channel request level from the HPS (asynchronous)
//   hps_burst     per-channel mode, sampled at capture: 1 = auto-increment address
//   hps_addr      shared HPS address
//   hps_data      shared HPS write data
//   wr_ready      per-consumer ready; a channel is granted only while its bit is high
//   clr_err       synchronous clear of err_abort
//   hps_ack       per-channel acknowledge back to the HPS
//   wr_en         one-hot, single-cycle write strobe
//   wr_addr       write address, qualified by wr_en, held otherwise
//   wr_data       write data, qualified by wr_en, held otherwise
//   err_abort     sticky per-channel flag: activate dropped before ack
//   write_count   total writes issued, wraps modulo 2^CNT_W
module hps_pio_bridge #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              CLOCK_50,
  input  logic              hps_reset,
  input  logic [NUM_CH-1:0] hps_activate,
  input  logic [NUM_CH-1:0] hps_burst,
  input  logic [ADDR_W-1:0] hps_addr,
  input  logic [DATA_W-1:0] hps_data,
  input  logic [NUM_CH-1:0] wr_ready,
  input  logic              clr_err,
  output logic [NUM_CH-1:0] hps_ack,
  output logic [NUM_CH-1:0] wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [NUM_CH-1:0] err_abort,
  output logic [CNT_W-1:0]  write_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } ch_state_t;

  ch_state_t state      [NUM_CH];
  ch_state_t state_next [NUM_CH];

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s, s_d, rise, fall;

  logic [ADDR_W-1:0] cap_addr  [NUM_CH];
  logic [DATA_W-1:0] cap_data  [NUM_CH];
  logic [ADDR_W-1:0] next_addr [NUM_CH];
  logic [ADDR_W-1:0] prev_next [NUM_CH];
  logic [ADDR_W-1:0] capt_addr [NUM_CH];

  logic [NUM_CH-1:0] capture, abort, eligible, grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Synchroniser chain, plus one extra flop so edges of the synchronised level
  // can be detected.
  always_ff @(posedge CLOCK_50 or posedge hps_reset) begin
    if (hps_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= hps_activate;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_ff @(posedge CLOCK_50 or posedge hps_reset) begin
    if (hps_reset) begin
      for (int i = 0; i < NUM_CH; i++) state[i] <= IDLE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) state[i] <= state_next[i];
    end
  end

  always_comb begin
    capture  = '0;
    abort    = '0;
    eligible = '0;
    grant    = '0;
    sel_addr = wr_addr;
    sel_data = wr_data;
    for (int i = 0; i < NUM_CH; i++) begin
      state_next[i] = state[i];
      capt_addr[i]  = hps_burst[i] ? next_addr[i] : hps_addr;
      capture[i]    = (state[i] == IDLE) && rise[i];
      abort[i]      = (state[i] == PEND) && fall[i];
      // A channel whose activate is already falling aborts, so it must not win the bus.
      eligible[i]   = (state[i] == PEND) && wr_ready[i] && !fall[i];
    end

    // Isolate the lowest set bit, so the lowest-index eligible channel wins.
    grant = eligible & (~eligible + NUM_CH'(1));

    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_addr = cap_addr[i];
        sel_data = cap_data[i];
      end
      case (state[i])
        IDLE: if (capture[i]) state_next[i] = PEND;
        PEND: begin
          if (abort[i])      state_next[i] = IDLE;
          else if (grant[i]) state_next[i] = ACK;
        end
        ACK:  if (fall[i])   state_next[i] = IDLE;
        default:             state_next[i] = IDLE;
      endcase
    end
  end

  // Per-channel capture. prev_next keeps the auto-increment pointer from before
  // the capture, so an aborted request leaves the burst sequence unchanged.
  always_ff @(posedge CLOCK_50 or posedge hps_reset) begin
    if (hps_reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cap_addr[i]  <= '0;
        cap_data[i]  <= '0;
        next_addr[i] <= '0;
        prev_next[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture[i]) begin
          cap_data[i]  <= hps_data;
          cap_addr[i]  <= capt_addr[i];
          next_addr[i] <= capt_addr[i] + ADDR_W'(1);
          prev_next[i] <= next_addr[i];
        end else if (abort[i]) begin
          next_addr[i] <= prev_next[i];
        end
      end
    end
  end

  // Registered outputs. In err_abort, a set in the same cycle as clr_err wins.
  always_ff @(posedge CLOCK_50 or posedge hps_reset) begin
    if (hps_reset) begin
      hps_ack     <= '0;
      wr_en       <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      err_abort   <= '0;
      write_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) hps_ack[i] <= (state_next[i] == ACK);
      wr_en <= grant;
      if (|grant) begin
        wr_addr     <= sel_addr;
        wr_data     <= sel_data;
        write_count <= write_count + CNT_W'(1);
      end
      err_abort <= (err_abort & ~{NUM_CH{clr_err}}) | abort;
    end
  end

endmodule

// File: tb/tb_hps_pio_bridge.sv
`timescale 1ns/1ps
// tb_hps_pio_bridge
// Drives directed and random handshakes into hps_pio_bridge. Each wr_en pulse
// is compared against a queue of expected writes. The bench builds that queue
// from the HPS-side view: which channel, which address rule, which data.
module tb_hps_pio_bridge;

  localparam int NUM_CH = 2;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              CLOCK_50;
  logic              hps_reset;
  logic [NUM_CH-1:0] hps_activate;
  logic [NUM_CH-1:0] hps_burst;
  logic [ADDR_W-1:0] hps_addr;
  logic [DATA_W-1:0] hps_data;
  logic [NUM_CH-1:0] wr_ready;
  logic              clr_err;
  logic [NUM_CH-1:0] hps_ack;
  logic [NUM_CH-1:0] wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NUM_CH-1:0] err_abort;
  logic [CNT_W-1:0]  write_count;

  hps_pio_bridge #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2), .CNT_W(CNT_W)
  ) dut (
    .CLOCK_50(CLOCK_50), .hps_reset(hps_reset), .hps_activate(hps_activate),
    .hps_burst(hps_burst), .hps_addr(hps_addr), .hps_data(hps_data),
    .wr_ready(wr_ready), .clr_err(clr_err), .hps_ack(hps_ack), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .err_abort(err_abort),
    .write_count(write_count)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int                ch;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_wr_t;

  exp_wr_t           exp_q[$];
  logic [ADDR_W-1:0] model_next [NUM_CH];
  int                model_count;
  int                num_checks;
  int                num_fails;
  int                mon_ch;
  int                mon_idx;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected write for one accepted request: a burst takes the channel's running
  // pointer, otherwise the bus address; either way the pointer moves to addr+1.
  task automatic modelWrite(input int ch, input logic burst, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data);
    exp_wr_t e;
    e.ch   = ch;
    e.addr = burst ? model_next[ch] : addr;
    e.data = data;
    model_next[ch] = ADDR_W'((int'(e.addr) + 1) % (1 << ADDR_W));
    exp_q.push_back(e);
  endtask

  task automatic modelReset();
    exp_q.delete();
    for (int i = 0; i < NUM_CH; i++) model_next[i] = '0;
    model_count = 0;
  endtask

  // Every write strobe must be one-hot and match the oldest outstanding
  // expectation for its channel.
  always @(negedge CLOCK_50) begin
    if (!hps_reset && wr_en != '0) begin
      checkOutput("wr_en_onehot", 64'($onehot(wr_en)), 64'd1);
      mon_ch = 0;
      for (int i = 0; i < NUM_CH; i++) if (wr_en[i]) mon_ch = i;
      mon_idx = -1;
      for (int j = 0; j < exp_q.size(); j++) if (mon_idx < 0 && exp_q[j].ch == mon_ch) mon_idx = j;
      checkOutput("wr_expected", 64'(mon_idx >= 0), 64'd1);
      if (mon_idx >= 0) begin
        checkOutput("wr_addr", 64'(wr_addr), 64'(exp_q[mon_idx].addr));
        checkOutput("wr_data", 64'(wr_data), 64'(exp_q[mon_idx].data));
        exp_q.delete(mon_idx);
        model_count = (model_count + 1) % (1 << CNT_W);
        checkOutput("write_count", 64'(write_count), 64'(model_count));
      end
    end
  end

  // Full handshake on one channel, with a bounded wait for ack rise and fall.
  // When rand_ready is set, wr_ready is re-randomised every cycle while waiting.
  task automatic applyStimulus(input int ch, input logic burst, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input bit rand_ready);
    int cyc;
    modelWrite(ch, burst, addr, data);
    @(negedge CLOCK_50);
    hps_addr         = addr;
    hps_data         = data;
    hps_burst[ch]    = burst;
    hps_activate[ch] = 1'b1;
    cyc = 0;
    while (!hps_ack[ch] && cyc < 100) begin
      @(negedge CLOCK_50);
      if (rand_ready) wr_ready = NUM_CH'($urandom);
      cyc++;
    end
    checkOutput("ack_rise", 64'(hps_ack[ch]), 64'd1);
    hps_activate[ch] = 1'b0;
    wr_ready = '1;
    cyc = 0;
    while (hps_ack[ch] && cyc < 20) begin
      @(negedge CLOCK_50);
      cyc++;
    end
    checkOutput("ack_fall", 64'(hps_ack[ch]), 64'd0);
  endtask

  // Request that is withdrawn while its consumer is stalled.
  task automatic applyAbort(input int ch, input logic burst);
    @(negedge CLOCK_50);
    wr_ready[ch]     = 1'b0;
    hps_addr         = ADDR_W'($urandom);
    hps_data         = $urandom;
    hps_burst[ch]    = burst;
    hps_activate[ch] = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    hps_activate[ch] = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    checkOutput("abort_err", 64'(err_abort), 64'(1 << ch));
    checkOutput("abort_ack", 64'(hps_ack[ch]), 64'd0);
    clr_err = 1'b1;
    @(negedge CLOCK_50);
    clr_err = 1'b0;
    checkOutput("abort_clr", 64'(err_abort), 64'd0);
    wr_ready = '1;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    num_checks   = 0;
    num_fails    = 0;
    hps_reset    = 1'b1;
    hps_activate = '0;
    hps_burst    = '0;
    hps_addr     = '0;
    hps_data     = '0;
    wr_ready     = '0;
    clr_err      = 1'b0;
    modelReset();
    repeat (3) @(negedge CLOCK_50);
    checkOutput("rst_ack", 64'(hps_ack), 64'd0);
    checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
    checkOutput("rst_err", 64'(err_abort), 64'd0);
    checkOutput("rst_count", 64'(write_count), 64'd0);
    hps_reset = 1'b0;
    wr_ready  = '1;

    // Single write with exact latency and ack release timing
    @(negedge CLOCK_50);
    modelWrite(0, 1'b0, 15'h0123, 32'hDEADBEEF);
    hps_addr = 15'h0123; hps_data = 32'hDEADBEEF; hps_burst = '0;
    hps_activate = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLOCK_50);
      checkOutput("t1_early_wr_en", 64'(wr_en), 64'd0);
      checkOutput("t1_early_ack", 64'(hps_ack), 64'd0);
    end
    @(negedge CLOCK_50);
    checkOutput("t1_wr_en", 64'(wr_en), 64'h1);
    checkOutput("t1_ack", 64'(hps_ack), 64'h1);
    checkOutput("t1_addr", 64'(wr_addr), 64'h0123);
    checkOutput("t1_count", 64'(write_count), 64'd1);
    @(negedge CLOCK_50);
    checkOutput("t1_wr_en_single", 64'(wr_en), 64'd0);
    checkOutput("t1_ack_hold", 64'(hps_ack), 64'h1);
    hps_activate = 2'b00;
    for (int k = 1; k <= 2; k++) begin
      @(negedge CLOCK_50);
      checkOutput("t1_ack_still", 64'(hps_ack), 64'h1);
    end
    @(negedge CLOCK_50);
    checkOutput("t1_ack_release", 64'(hps_ack), 64'd0);

    // Burst addressing wraps across the top of the address space
    applyStimulus(0, 1'b0, 15'h7FFE, 32'h0000_0000, 1'b0);
    applyStimulus(0, 1'b1, 15'h1234, 32'h0000_0001, 1'b0);
    applyStimulus(0, 1'b1, 15'h2345, 32'h0000_0002, 1'b0);
    applyStimulus(0, 1'b1, 15'h3456, 32'h0000_0003, 1'b0);
    checkOutput("t2_next_burst_ptr", 64'(model_next[0]), 64'h0002);

    // Simultaneous rise on both channels: ch0 first, ch1 one cycle later
    @(negedge CLOCK_50);
    modelWrite(0, 1'b0, 15'h0AAA, 32'h5555AAAA);
    modelWrite(1, 1'b0, 15'h0AAA, 32'h5555AAAA);
    hps_addr = 15'h0AAA; hps_data = 32'h5555AAAA; hps_burst = '0;
    hps_activate = 2'b11;
    repeat (3) @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checkOutput("t3_first", 64'(wr_en), 64'h1);
    @(negedge CLOCK_50);
    checkOutput("t3_second", 64'(wr_en), 64'h2);
    checkOutput("t3_acks", 64'(hps_ack), 64'h3);
    hps_activate = 2'b00;
    repeat (4) @(negedge CLOCK_50);
    checkOutput("t3_ack_release", 64'(hps_ack), 64'd0);

    // ch0 stalled by wr_ready; ch1 completes while ch0 waits
    @(negedge CLOCK_50);
    wr_ready = 2'b10;
    modelWrite(0, 1'b0, 15'h0100, 32'h11110000);
    hps_addr = 15'h0100; hps_data = 32'h11110000; hps_burst = '0;
    hps_activate[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLOCK_50);
      checkOutput("t4_stall_wr_en0", 64'(wr_en[0]), 64'd0);
      checkOutput("t4_stall_ack0", 64'(hps_ack[0]), 64'd0);
      if (k == 4) begin
        modelWrite(1, 1'b0, 15'h0200, 32'h22220000);
        hps_addr = 15'h0200; hps_data = 32'h22220000;
        hps_activate[1] = 1'b1;
      end
      if (k == 8) begin
        checkOutput("t4_ch1_wr_en", 64'(wr_en), 64'h2);
        hps_activate[1] = 1'b0;
      end
      if (k == 10) wr_ready = 2'b11;
    end
    @(negedge CLOCK_50);
    checkOutput("t4_release_wr_en", 64'(wr_en), 64'h1);
    checkOutput("t4_release_ack", 64'(hps_ack), 64'h1);
    hps_activate[0] = 1'b0;
    repeat (4) @(negedge CLOCK_50);

    // Abort on ch1 with clr_err landing on the same edge as the set
    @(negedge CLOCK_50);
    wr_ready = 2'b01;
    hps_addr = 15'h4444; hps_data = 32'hCAFEF00D; hps_burst[1] = 1'b1;
    hps_activate[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLOCK_50);
      checkOutput("t5_no_ack", 64'(hps_ack[1]), 64'd0);
    end
    hps_activate[1] = 1'b0;
    for (int k = 5; k <= 6; k++) begin
      @(negedge CLOCK_50);
      checkOutput("t5_err_before", 64'(err_abort), 64'd0);
    end
    clr_err = 1'b1;
    @(negedge CLOCK_50);
    clr_err = 1'b0;
    checkOutput("t5_set_wins", 64'(err_abort), 64'h2);
    @(negedge CLOCK_50);
    checkOutput("t5_sticky", 64'(err_abort), 64'h2);
    clr_err = 1'b1;
    @(negedge CLOCK_50);
    clr_err = 1'b0;
    checkOutput("t5_cleared", 64'(err_abort), 64'd0);
    wr_ready = '1;
    applyStimulus(1, 1'b1, 15'h0777, 32'h0BADCAFE, 1'b0);

    // Reset while ch0 is pending
    @(negedge CLOCK_50);
    wr_ready = 2'b10;
    hps_addr = 15'h0555; hps_data = 32'h12345678; hps_burst = '0;
    hps_activate[0] = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    #3;
    hps_reset    = 1'b1;
    hps_activate = '0;
    modelReset();
    #1;
    checkOutput("t6_ack", 64'(hps_ack), 64'd0);
    checkOutput("t6_wr_en", 64'(wr_en), 64'd0);
    checkOutput("t6_addr", 64'(wr_addr), 64'd0);
    checkOutput("t6_data", 64'(wr_data), 64'd0);
    checkOutput("t6_err", 64'(err_abort), 64'd0);
    checkOutput("t6_count", 64'(write_count), 64'd0);
    @(negedge CLOCK_50);
    hps_reset = 1'b0;
    wr_ready  = '1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLOCK_50);
      checkOutput("t6_no_wr_after", 64'(wr_en), 64'd0);
    end
    applyStimulus(0, 1'b1, 15'h3333, 32'hA5A5A5A5, 1'b0);

    // Random traffic, mixing plain, burst, stalled and aborted requests
    for (int n = 0; n < 40; n++) begin
      int ch;
      ch = int'($urandom_range(0, NUM_CH - 1));
      if ($urandom_range(0, 5) == 0)
        applyAbort(ch, 1'($urandom));
      else
        applyStimulus(ch, 1'($urandom), ADDR_W'($urandom), $urandom, 1'b1);
    end

    repeat (5) @(negedge CLOCK_50);
    checkOutput("leftover_writes", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
    $finish;
  end

endmodule
